// File: rtl/biquad8_coeff_loader_pkg.sv
// Shared types for the biquad8 coefficient loader: FSM states, table entry layout
// and the fixed update-strobe write.
package biquad8_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        WRITE,
        GAP,
        UPDATE,
        ABORT,
        DONE
    } state_t;

    // One table word as stored in the coefficient BRAM/ROM.
    typedef struct packed {
        logic [6:0]  adr;
        logic [17:0] dat;
    } coeff_entry_t;

    localparam int          TBL_W      = $bits(coeff_entry_t);
    localparam logic [6:0]  UPDATE_ADR = 7'h00;
    localparam logic [31:0] UPDATE_DAT = 32'h0000_0001;

    function automatic logic [31:0] sext18(input logic [17:0] v);
        return {{14{v[17]}}, v};
    endfunction

endpackage

// File: rtl/biquad8_coeff_loader_if.sv
// Classic single-transfer WISHBONE write bus between the loader (master) and
// the biquad8 coefficient target (slave).
interface biquad8_coeff_loader_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [6:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, dat, sel,
        input  ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat, sel,
        output ack, err, rty
    );

endinterface

// File: rtl/biquad8_coeff_loader_wb_term_timer.sv
// Bus termination watchdog: cleared at the start of each strobe, counts enabled
// cycles and flags the last permitted cycle so the initiator can abort.
module wb_term_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        // NOTE: the hold value is assigned first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: flops use <= so every register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires in the TIMEOUT-th enabled cycle, so the strobe is held exactly TIMEOUT cycles.
    assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/biquad8_coeff_loader.sv
// WISHBONE initiator that copies {adr, coeff} table entries into a biquad8 target
// one single write at a time, then issues the update strobe so they go live together.
module biquad8_coeff_loader
    import biquad8_loader_pkg::*;
#(
    parameter int MAX_ENTRY = 32,
    parameter int TIMEOUT   = 1023,
    parameter int MAX_RETRY = 3,
    parameter bit DO_UPDATE = 1'b1
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           start_i,
    input  logic [$clog2(MAX_ENTRY):0]     nentry_i,
    output logic [$clog2(MAX_ENTRY)-1:0]   tbl_adr_o,
    input  logic [TBL_W-1:0]               tbl_dat_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    biquad8_coeff_loader_if.master         wb
);

    localparam int AW = $clog2(MAX_ENTRY);
    localparam int NW = AW + 1;
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;

    state_t        state_q, state_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [NW-1:0] nentry_q, nentry_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          retry_pend_q, retry_pend_d;
    logic          upd_q, upd_d;
    logic          cyc_q, cyc_d;
    logic [6:0]    adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_expired;
    coeff_entry_t  entry;

    assign entry = coeff_entry_t'(tbl_dat_i);

    wb_term_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_term_timer (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        nentry_d     = nentry_q;
        retry_d      = retry_q;
        retry_pend_d = retry_pend_q;
        upd_d        = upd_q;
        cyc_d        = cyc_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        err_d        = err_q;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;

        unique case (state_q)
            // DONE accepts a start too, since busy_o is already low there.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    err_d    = 1'b0;
                    idx_d    = '0;
                    nentry_d = nentry_i;
                    if (nentry_i != '0) begin
                        state_d = FETCH;
                    end else if (DO_UPDATE) begin
                        state_d = UPDATE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            FETCH: begin
                state_d = WAIT;
            end

            WAIT: begin
                adr_d        = {entry.adr[6:2], 2'b00};
                dat_d        = sext18(entry.dat);
                upd_d        = 1'b0;
                retry_d      = '0;
                retry_pend_d = 1'b0;
                cyc_d        = 1'b1;
                tmr_clr      = 1'b1;
                state_d      = WRITE;
            end

            UPDATE: begin
                adr_d        = UPDATE_ADR;
                dat_d        = UPDATE_DAT;
                upd_d        = 1'b1;
                retry_d      = '0;
                retry_pend_d = 1'b0;
                cyc_d        = 1'b1;
                tmr_clr      = 1'b1;
                state_d      = WRITE;
            end

            WRITE: begin
                tmr_en = 1'b1;
                if (wb.err) begin
                    cyc_d   = 1'b0;
                    state_d = ABORT;
                end else if (wb.rty) begin
                    cyc_d = 1'b0;
                    if (retry_q >= RW'(MAX_RETRY)) begin
                        state_d = ABORT;
                    end else begin
                        retry_d      = retry_q + RW'(1);
                        retry_pend_d = 1'b1;
                        state_d      = GAP;
                    end
                end else if (wb.ack) begin
                    cyc_d = 1'b0;
                    if (upd_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + NW'(1);
                        state_d = GAP;
                    end
                end else if (tmr_expired) begin
                    cyc_d   = 1'b0;
                    state_d = ABORT;
                end
            end

            // One idle bus cycle so the target sees cyc low; a retry reuses the held adr/dat.
            GAP: begin
                if (retry_pend_q) begin
                    retry_pend_d = 1'b0;
                    cyc_d        = 1'b1;
                    tmr_clr      = 1'b1;
                    state_d      = WRITE;
                end else if (idx_q < nentry_q) begin
                    state_d = FETCH;
                end else if (DO_UPDATE) begin
                    state_d = UPDATE;
                end else begin
                    state_d = DONE;
                end
            end

            ABORT: begin
                err_d   = 1'b1;
                state_d = DONE;
            end

            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = !(state_d inside {IDLE, DONE});
        done_d = (state_d == DONE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            nentry_q     <= '0;
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
            upd_q        <= 1'b0;
            cyc_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            nentry_q     <= nentry_d;
            retry_q      <= retry_d;
            retry_pend_q <= retry_pend_d;
            upd_q        <= upd_d;
            cyc_q        <= cyc_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign tbl_adr_o = idx_q[AW-1:0];
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

    // Single outstanding write: stb and we simply follow cyc.
    assign wb.cyc = cyc_q;
    assign wb.stb = cyc_q;
    assign wb.we  = cyc_q;
    assign wb.adr = adr_q;
    assign wb.dat = dat_q;
    assign wb.sel = 4'b1111;

endmodule
